rv2t_pipeline_sequencer: RTL and testbench
==========================================

// Module: rv2t_pipeline_sequencer
//
// PURPOSE
//  Multi-cycle sequencer for the RV2T core: steps each instruction through FETCH -> DECODE -> EXEC
//  (-> MEM) and drives the per-stage enables, including decode_enable into the instruction decoder.
//  Consumes the decoder's control flags (load/store/WFI/MRET/illegal) to choose the next state.
//  Handles trap entry on illegal instruction or pending interrupt. Counts retired instructions.
//
// PARAMETERS
//  COUNTER_BITS        32   width of retired_count; wraps modulo 2^COUNTER_BITS
//  MEM_TIMEOUT_CYCLES  255  MEM-state cycles without mem_ack before timeout (only with RV2T_MEM_TIMEOUT_EN)
//
// PORTS
//  clk                            in   1   core clock
//  reset_n                        in   1   asynchronous, active-low reset
//  sync_reset                     in   1   synchronous clear: state->IDLE, counters->0
//  start                          in   1   leave IDLE (level; sampled in IDLE only)
//  fetch_valid                    in   1   fetched word presented to the decoder this cycle
//  ctl_LOAD / ctl_STORE           in   1   decoder flags, valid in EXEC
//  ctl_WFI / ctl_MRET             in   1   decoder flags, valid in EXEC
//  exception_illegal_instruction  in   1   decoder illegal flag, valid in EXEC
//  branch_taken                   in   1   execute unit: taken branch/JAL/JALR, valid in EXEC
//  mem_ack                        in   1   data-memory completion, valid in MEM
//  interrupt_pending              in   1   enabled-and-pending interrupt from CSR block
//  fetch_enable                   out  1   high throughout FETCH
//  decode_enable                  out  1   high for exactly the one DECODE cycle
//  exe_enable                     out  1   high for exactly the one EXEC cycle
//  mem_enable                     out  1   high throughout MEM
//  pc_redirect                    out  1   1-cycle pulse: PC is loaded from branch/MRET/trap target
//  trap_enter                     out  1   1-cycle pulse in TRAP: save mepc/mcause
//  mret_out                       out  1   1-cycle pulse on EXEC->FETCH transition for MRET
//  mem_timeout_exception          out  1   1-cycle pulse with trap_enter on memory timeout (0 if macro off)
//  retired_count                  out  COUNTER_BITS  retired-instruction count
//  state_out                      out  3   current state encoding (debug)
//
// BEHAVIOUR
//  - States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WFI=5 TRAP=6; code 7 is unreachable and recovers to IDLE.
//  - Reset (async or sync_reset): state=IDLE, retired_count=0, timeout counter=0, all outputs 0.
//  - Outputs are registered (next-state decode): each is valid in the same cycle as its state, glitch-free.
//  - IDLE:   start=1 -> FETCH.
//  - FETCH:  interrupt_pending -> TRAP (priority); else fetch_valid -> DECODE; else hold.
//  - DECODE: unconditional -> EXEC (decoder registers IR here; its flags are valid in EXEC).
//  - EXEC:   priority order:
//      1. illegal -> TRAP
//      2. LOAD|STORE -> MEM
//      3. WFI -> WFI, instruction retires
//      4. else -> FETCH, instruction retires
//    pc_redirect=1 on the EXEC->FETCH edge if branch_taken|ctl_MRET; mret_out=ctl_MRET on that edge.
//  - MEM:    mem_ack -> FETCH and retire; mem_ack while in another state is ignored.
//  - WFI:    interrupt_pending -> TRAP; else hold. All enables stay 0.
//  - TRAP:   one cycle, trap_enter=1, pc_redirect=1 -> FETCH. No retire.
//  - retired_count: +1 per retire event (at most one per cycle); wraps from all-ones to 0; never counts traps.
//  - Latency: non-memory instruction 3 cycles (FETCH with fetch_valid=1, DECODE, EXEC); load/store 3 + MEM cycles.
//  - sync_reset takes precedence over every transition in the same cycle.
//
// CONFIGURATION
//  RV2T_MEM_TIMEOUT_EN defined:
//    - 8-bit-min counter clears on MEM entry and increments each MEM cycle with mem_ack=0.
//    - On reaching MEM_TIMEOUT_CYCLES -> TRAP with mem_timeout_exception=1 alongside trap_enter.
//    - mem_ack in the same cycle the limit is reached wins: normal retire, no exception.
//  RV2T_MEM_TIMEOUT_EN not defined:
//    - No counter; MEM waits for mem_ack indefinitely.
//    - mem_timeout_exception tied to 0.
//
// TESTING
//  1. Reset, start=1, fetch_valid=1, ADDI flags all 0
//     -> state sequence 1,2,3,1; decode_enable one cycle; retired_count=1.
//  2. EXEC with ctl_LOAD=1, mem_ack held 0 for 4 cycles then 1
//     -> mem_enable high 5 cycles, FETCH next, retired_count+1.
//  3. EXEC with illegal=1 and ctl_STORE=1
//     -> TRAP (not MEM), trap_enter and pc_redirect one cycle, count unchanged.
//  4. EXEC with ctl_WFI=1, interrupt_pending asserted 10 cycles later
//     -> WFI holds 10 cycles, then TRAP, then FETCH.
//  5. Preload count to 2^COUNTER_BITS-1, retire one instruction
//     -> count=0. reset_n low in MEM -> IDLE, all outputs 0 immediately.
//  6. Macro on, MEM_TIMEOUT_CYCLES=4, mem_ack=0
//     -> TRAP after 4 MEM cycles with mem_timeout_exception=1; repeat with mem_ack on 4th cycle -> normal retire.

Source files
------------

// File: rtl/rv2t_pipeline_sequencer_if.sv
// rv2t_pipeline_sequencer_if: control bundle between the RV2T sequencer and its core.
// master = sequencer (drives enables/pulses/count); slave = core side (drives flags).
// Signals: start, fetch_valid, ctl_LOAD/STORE/WFI/MRET, exception_illegal_instruction,
//   branch_taken, mem_ack, interrupt_pending (to sequencer); fetch/decode/exe/mem_enable,
//   pc_redirect, trap_enter, mret_out, mem_timeout_exception, retired_count, state_out.
interface rv2t_pipeline_sequencer_if #(
    parameter int COUNTER_BITS = 32
);
    logic                    start;
    logic                    fetch_valid;
    logic                    ctl_LOAD;
    logic                    ctl_STORE;
    logic                    ctl_WFI;
    logic                    ctl_MRET;
    logic                    exception_illegal_instruction;
    logic                    branch_taken;
    logic                    mem_ack;
    logic                    interrupt_pending;
    logic                    fetch_enable;
    logic                    decode_enable;
    logic                    exe_enable;
    logic                    mem_enable;
    logic                    pc_redirect;
    logic                    trap_enter;
    logic                    mret_out;
    logic                    mem_timeout_exception;
    logic [COUNTER_BITS-1:0] retired_count;
    logic [2:0]              state_out;

    modport master (
        input  start, fetch_valid,
        input  ctl_LOAD, ctl_STORE, ctl_WFI, ctl_MRET,
        input  exception_illegal_instruction,
        input  branch_taken, mem_ack, interrupt_pending,
        output fetch_enable, decode_enable,
        output exe_enable, mem_enable,
        output pc_redirect, trap_enter, mret_out,
        output mem_timeout_exception,
        output retired_count, state_out
    );

    modport slave (
        output start, fetch_valid,
        output ctl_LOAD, ctl_STORE, ctl_WFI, ctl_MRET,
        output exception_illegal_instruction,
        output branch_taken, mem_ack, interrupt_pending,
        input  fetch_enable, decode_enable,
        input  exe_enable, mem_enable,
        input  pc_redirect, trap_enter, mret_out,
        input  mem_timeout_exception,
        input  retired_count, state_out
    );
endinterface

// File: rtl/rv2t_pipeline_sequencer.sv
// rv2t_pipeline_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM sequencer with trap entry
// and retired-instruction counter. Ports: clk, reset_n (async, active low), sync_reset,
// bus (rv2t_pipeline_sequencer_if.master). Optional macro RV2T_MEM_TIMEOUT_EN adds a
// MEM-state timeout that traps with mem_timeout_exception.
module rv2t_pipeline_sequencer #(
    parameter int COUNTER_BITS       = 32,
    parameter int MEM_TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_reset,
    rv2t_pipeline_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WFI    = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    retire;
    logic                    redir_d;
    logic                    mret_d;
    logic                    tmo_d;
    logic                    timeout_hit;
    logic [COUNTER_BITS-1:0] cnt_q;
    logic                    fetch_q;
    logic                    decode_q;
    logic                    exe_q;
    logic                    mem_q;
    logic                    redir_q;
    logic                    trap_q;
    logic                    mret_q;
    logic                    tmo_q;

`ifdef RV2T_MEM_TIMEOUT_EN
    localparam int TW_RAW = $clog2(MEM_TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW > 8) ? TW_RAW : 8;

    logic [TW-1:0] tcnt_q;

    // Counter holds the number of ack-less MEM cycles already spent, so the
    // limit is hit in the MEM cycle that would make it MEM_TIMEOUT_CYCLES.
    assign timeout_hit = (state_q == S_MEM) && !bus.mem_ack &&
                         (tcnt_q == TW'(MEM_TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_q <= '0;
        end else if (sync_reset) begin
            tcnt_q <= '0;
        end else if (state_q != S_MEM && state_d == S_MEM) begin
            tcnt_q <= '0;
        end else if (state_q == S_MEM && !bus.mem_ack) begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^MEM_TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        redir_d = 1'b0;
        mret_d  = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.interrupt_pending) begin
                    state_d = S_TRAP;
                end else if (bus.fetch_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (bus.exception_illegal_instruction) begin
                    state_d = S_TRAP;
                end else if (bus.ctl_LOAD || bus.ctl_STORE) begin
                    state_d = S_MEM;
                end else if (bus.ctl_WFI) begin
                    state_d = S_WFI;
                    retire  = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                    redir_d = bus.branch_taken | bus.ctl_MRET;
                    mret_d  = bus.ctl_MRET;
                end
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    tmo_d   = 1'b1;
                end
            end
            S_WFI: begin
                if (bus.interrupt_pending) state_d = S_TRAP;
            end
            S_TRAP: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the
    // state they belong to without a combinational path to the flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fetch_q  <= 1'b0;
            decode_q <= 1'b0;
            exe_q    <= 1'b0;
            mem_q    <= 1'b0;
            redir_q  <= 1'b0;
            trap_q   <= 1'b0;
            mret_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else if (sync_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fetch_q  <= 1'b0;
            decode_q <= 1'b0;
            exe_q    <= 1'b0;
            mem_q    <= 1'b0;
            redir_q  <= 1'b0;
            trap_q   <= 1'b0;
            mret_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fetch_q  <= (state_d == S_FETCH);
            decode_q <= (state_d == S_DECODE);
            exe_q    <= (state_d == S_EXEC);
            mem_q    <= (state_d == S_MEM);
            trap_q   <= (state_d == S_TRAP);
            redir_q  <= redir_d | (state_d == S_TRAP);
            mret_q   <= mret_d;
            tmo_q    <= tmo_d;
            if (retire) cnt_q <= cnt_q + COUNTER_BITS'(1);
        end
    end

    assign bus.fetch_enable          = fetch_q;
    assign bus.decode_enable         = decode_q;
    assign bus.exe_enable            = exe_q;
    assign bus.mem_enable            = mem_q;
    assign bus.pc_redirect           = redir_q;
    assign bus.trap_enter            = trap_q;
    assign bus.mret_out              = mret_q;
    assign bus.mem_timeout_exception = tmo_q;
    assign bus.retired_count         = cnt_q;
    assign bus.state_out             = state_q;

endmodule

// File: tb/tb_rv2t_pipeline_sequencer.sv
// tb_rv2t_pipeline_sequencer: random instruction stream against a per-instruction model;
// expected per-cycle outputs are queued by the driver and checked by a monitor.
module tb_rv2t_pipeline_sequencer;

    localparam int CB  = 4;
    localparam int LIM = 4;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WFI    = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;
`ifdef RV2T_MEM_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    typedef struct {
        logic [2:0] st;
        logic       rd;
        logic       mr;
        logic       to;
        int         cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic sync_reset;
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   mcnt   = 0;

    always #5 clk = ~clk;

    rv2t_pipeline_sequencer_if #(.COUNTER_BITS(CB)) bus ();

    rv2t_pipeline_sequencer #(
        .COUNTER_BITS      (CB),
        .MEM_TIMEOUT_CYCLES(LIM)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sync_reset(sync_reset),
        .bus       (bus)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: one expected record per clock cycle of the instruction stream.
    always @(posedge clk) begin : mon
        exp_t e;
        logic [14:0] got;
        logic [14:0] want;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got  = {bus.state_out, bus.fetch_enable, bus.decode_enable,
                    bus.exe_enable, bus.mem_enable, bus.pc_redirect,
                    bus.trap_enter, bus.mret_out, bus.mem_timeout_exception,
                    bus.retired_count};
            want = {e.st, e.st == S_FETCH, e.st == S_DECODE, e.st == S_EXEC,
                    e.st == S_MEM, e.rd, e.st == S_TRAP, e.mr, e.to,
                    CB'(e.cnt)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL cycle t=%0t st/fe/de/ee/me/pr/te/mo/to/cnt got %b expected %b",
                         $time, got, want);
            end
        end
    end

    // Queue the outputs expected in the next cycle, then advance one cycle.
    task automatic cyc(input logic [2:0] st, input logic rd, input logic mr, input logic to);
        exp_t e;
        e.st  = st;
        e.rd  = rd;
        e.mr  = mr;
        e.to  = to;
        e.cnt = mcnt;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic retire_one();
        mcnt = (mcnt + 1) % (1 << CB);
    endtask

    task automatic clear_flags();
        bus.ctl_LOAD                      = 1'b0;
        bus.ctl_STORE                     = 1'b0;
        bus.ctl_WFI                       = 1'b0;
        bus.ctl_MRET                      = 1'b0;
        bus.exception_illegal_instruction = 1'b0;
        bus.branch_taken                  = 1'b0;
    endtask

    // One instruction, entered at a negedge while in FETCH, left in FETCH.
    task automatic run_instr(input int fd, input bit irq, input bit ill,
                             input bit ld, input bit st, input bit wfi,
                             input bit mret, input bit br, input int md,
                             input int wd);
        bus.ctl_LOAD                      = ld;
        bus.ctl_STORE                     = st;
        bus.ctl_WFI                       = wfi;
        bus.ctl_MRET                      = mret;
        bus.exception_illegal_instruction = ill;
        bus.branch_taken                  = br;
        bus.mem_ack                       = 1'b0;
        bus.interrupt_pending             = 1'b0;
        bus.fetch_valid                   = 1'b0;
        repeat (fd) cyc(S_FETCH, 0, 0, 0);
        if (irq) begin
            bus.interrupt_pending = 1'b1;
            cyc(S_TRAP, 1, 0, 0);
            bus.interrupt_pending = 1'b0;
            cyc(S_FETCH, 0, 0, 0);
        end else begin
            bus.fetch_valid = 1'b1;
            cyc(S_DECODE, 0, 0, 0);
            bus.fetch_valid = 1'b0;
            cyc(S_EXEC, 0, 0, 0);
            if (ill) begin
                cyc(S_TRAP, 1, 0, 0);
                clear_flags();
                cyc(S_FETCH, 0, 0, 0);
            end else if (ld || st) begin
                cyc(S_MEM, 0, 0, 0);
                clear_flags();
                if (TMO && md >= LIM) begin
                    repeat (LIM - 1) cyc(S_MEM, 0, 0, 0);
                    cyc(S_TRAP, 1, 0, 1);
                    cyc(S_FETCH, 0, 0, 0);
                end else begin
                    repeat (md) cyc(S_MEM, 0, 0, 0);
                    bus.mem_ack = 1'b1;
                    retire_one();
                    cyc(S_FETCH, 0, 0, 0);
                    bus.mem_ack = 1'b0;
                end
            end else if (wfi) begin
                retire_one();
                cyc(S_WFI, 0, 0, 0);
                clear_flags();
                repeat (wd) cyc(S_WFI, 0, 0, 0);
                bus.interrupt_pending = 1'b1;
                cyc(S_TRAP, 1, 0, 0);
                bus.interrupt_pending = 1'b0;
                cyc(S_FETCH, 0, 0, 0);
            end else begin
                retire_one();
                cyc(S_FETCH, br | mret, mret, 0);
            end
        end
        clear_flags();
    endtask

    // Walk a load into its first MEM cycle (negedge) without finishing it.
    task automatic enter_mem();
        bus.ctl_LOAD    = 1'b1;
        bus.fetch_valid = 1'b1;
        cyc(S_DECODE, 0, 0, 0);
        bus.fetch_valid = 1'b0;
        cyc(S_EXEC, 0, 0, 0);
        cyc(S_MEM, 0, 0, 0);
        clear_flags();
    endtask

    initial begin
        reset_n               = 1'b0;
        sync_reset            = 1'b0;
        bus.start             = 1'b0;
        bus.fetch_valid       = 1'b0;
        bus.mem_ack           = 1'b0;
        bus.interrupt_pending = 1'b0;
        clear_flags();
        repeat (2) @(negedge clk);
        chk("reset_state", 32'(bus.state_out), 32'd0);
        chk("reset_enables", 32'({bus.fetch_enable, bus.decode_enable,
            bus.exe_enable, bus.mem_enable}), 32'd0);
        chk("reset_pulses", 32'({bus.pc_redirect, bus.trap_enter,
            bus.mret_out, bus.mem_timeout_exception}), 32'd0);
        chk("reset_count", 32'(bus.retired_count), 32'd0);
        reset_n = 1'b1;
        cyc(S_IDLE, 0, 0, 0);
        bus.start = 1'b1;
        cyc(S_FETCH, 0, 0, 0);
        bus.start = 1'b0;

        run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, 4, 0);
        run_instr(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, 9);
        run_instr(2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 0, 1, 0, 0, 0, LIM - 1, 0);
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, LIM + 2, 0);
        run_instr(0, 0, 0, 1, 0, 1, 1, 1, 0, 0);

        for (int i = 0; i < 80; i++) begin
            run_instr($urandom_range(0, 2),
                      $urandom_range(0, 11) == 0,
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 4) == 0,
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 2) == 0,
                      $urandom_range(0, 6),
                      $urandom_range(0, 4));
        end

        enter_mem();
        sync_reset  = 1'b1;
        bus.mem_ack = 1'b1;
        mcnt        = 0;
        cyc(S_IDLE, 0, 0, 0);
        sync_reset  = 1'b0;
        bus.mem_ack = 1'b0;
        bus.start   = 1'b1;
        cyc(S_FETCH, 0, 0, 0);
        bus.start   = 1'b0;
        run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        enter_mem();
        reset_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(bus.state_out), 32'd0);
        chk("async_rst_mem_enable", 32'(bus.mem_enable), 32'd0);
        chk("async_rst_count", 32'(bus.retired_count), 32'd0);
        @(negedge clk);
        chk("async_rst_hold", 32'(bus.state_out), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
